// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- initiator side of the drom data-RAM port.
//
// Takes one load/store request at a time from the core LSU and turns it into a
// drom access. Store data is replicated across byte lanes and the matching byte
// enables are raised. Load data is shifted down to its lane, then sign- or
// zero-extended. Each request ends with a single-cycle response pulse.
//
// Parameters
//   ADDR_WIDTH  drom word-address width; the byte window is 2**(ADDR_WIDTH+2)
//   RD_LATENCY  drom read latency in cycles (1 or 2)
//   BASE_ADDR   byte base of the RAM window (aligned to the window size)
//
// Optional feature
//   DMEM_CTRL_RANGE_CHECK_EN  when defined, an address outside the window is
//                             answered with rsp_err and causes no RAM access;
//                             otherwise the upper address bits alias.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (accept on both high)
//   req_we, req_addr, req_size,   store flag, byte address, size (0/1/2),
//   req_unsigned, req_wdata       zero-extend flag, right-justified store data
//   rsp_valid, rsp_rdata, rsp_err single-cycle response, load data, error flag
//   ram_addr, ram_wr_data,        drom word address, lane-replicated write data,
//   ram_wr_en, ram_wr_byte_en     write strobe and byte enables
//   ram_rd_data                   drom read data
module dmem_ctrl #(
    parameter int          ADDR_WIDTH = 14,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wr_data,
    output logic                  ram_wr_en,
    output logic [3:0]            ram_wr_byte_en,
    input  logic [31:0]           ram_rd_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] LAST_WAIT = 2'(RD_LATENCY - 1);

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic                    uns_q, uns_d;
    logic [1:0]              size_q, size_d;
    logic [1:0]              lane_q, lane_d;
    logic                    err_q, err_d;
    logic [1:0]              wait_cnt_q, wait_cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]             ram_wr_data_q, ram_wr_data_d;
    logic                    ram_wr_en_q, ram_wr_en_d;
    logic [3:0]              ram_wr_be_q, ram_wr_be_d;

    logic                    misaligned;
    logic                    out_of_range;
    logic                    req_err;
    logic [3:0]              req_be;
    logic [31:0]             req_lane_data;

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            2'd0:    load_extend = uns ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_extend = uns ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_extend = shifted;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;   // size 3 is illegal
        endcase
    end

`ifdef DMEM_CTRL_RANGE_CHECK_EN
    localparam logic [31:0] HI_MASK = ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);
    assign out_of_range = (((req_addr ^ BASE_ADDR) & HI_MASK) != 32'h0);
`else
    // Upper address bits alias into the window and are deliberately ignored.
    logic unused_hi;
    assign unused_hi    = ^{req_addr[31:ADDR_WIDTH+2], BASE_ADDR};
    assign out_of_range = 1'b0;
`endif

    assign req_err = misaligned | out_of_range;

    always_comb begin
        req_be        = 4'b1111;
        req_lane_data = req_wdata;
        case (req_size)
            2'd0: begin
                req_be        = 4'b0001 << req_addr[1:0];
                req_lane_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                req_lane_data = {2{req_wdata[15:0]}};
            end
            default: begin
                req_be        = 4'b1111;
                req_lane_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        uns_d         = uns_q;
        size_d        = size_q;
        lane_d        = lane_q;
        err_d         = err_q;
        wait_cnt_d    = wait_cnt_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        // Strobes and the response are pulses; they default low every cycle.
        ram_wr_en_d   = 1'b0;
        ram_wr_be_d   = 4'b0000;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = 32'h0;

        case (state_q)
            // Accept: latch the request and set up the ISSUE-cycle outputs.
            IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    uns_d      = req_unsigned;
                    size_d     = req_size;
                    lane_d     = req_addr[1:0];
                    err_d      = req_err;
                    ram_addr_d = req_addr[ADDR_WIDTH+1:2];
                    if (req_we && !req_err) begin
                        ram_wr_en_d   = 1'b1;
                        ram_wr_be_d   = req_be;
                        ram_wr_data_d = req_lane_data;
                    end
                    state_d = ISSUE;
                end
            end
            // Address is on the RAM; stores and errors respond next cycle.
            ISSUE: begin
                if (!err_q && !we_q) begin
                    wait_cnt_d = 2'd0;
                    state_d    = WAIT;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    state_d     = RESP;
                end
            end
            // Read data arrives RD_LATENCY cycles after ISSUE.
            WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_extend(ram_rd_data, lane_q, size_q, uns_q);
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            // Response pulse is on the outputs this cycle.
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= 2'd0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= 32'h0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_be_q   <= 4'b0000;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_be_q   <= ram_wr_be_d;
            we_q          <= we_d;
            uns_q         <= uns_d;
            size_q        <= size_d;
            lane_q        <= lane_d;
            err_q         <= err_d;
        end
    end

    assign req_ready      = (state_q == IDLE) && !rst;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wr_data    = ram_wr_data_q;
    assign ram_wr_en      = ram_wr_en_q;
    assign ram_wr_byte_en = ram_wr_be_q;

endmodule
